// File: rtl/deadlock_mon_pkg.sv
// Shared types and defaults for the kernel deadlock monitor.
package deadlock_mon_pkg;

  localparam int DEFAULT_STALL_CYCLES = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WATCH   = 2'd1,
    S_BLOCKED = 2'd2
  } stall_state_e;

endpackage

// File: rtl/deadlock_stall_counter.sv
// Saturating run-length counter for the stall detector.
// restart loads the count with inc (0 or 1); otherwise inc advances it,
// saturating at STALL_CYCLES so it never wraps. hit flags STALL_CYCLES-1.
module deadlock_stall_counter
  import deadlock_mon_pkg::*;
#(
  parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic restart,
  output logic hit
);

  localparam int CW = $clog2(STALL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALL_CYCLES);
  localparam logic [CW-1:0] HIT_VAL = CW'(STALL_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Run-length count: restart seeds 0/1, inc steps up to the saturation value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= {{(CW-1){1'b0}}, inc};
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == HIT_VAL);

endmodule

// File: rtl/deadlock_stall_detector.sv
// Per-kernel deadlock decision stage. Declares deadlock once a stall pattern
// (blocked streams / blocked instances, kernel not fully idle) has held
// unchanged for STALL_CYCLES consecutive edges; block is sticky until reset.
// Optional build macro: DEADLOCK_STALL_REPORT_EN adds a free-running cycle
// counter and a one-shot simulation message when deadlock is declared.
module deadlock_stall_detector
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_AXIS     = 3,
  parameter int NUM_INST     = 3,
  parameter int NUM_BLK      = 1,
  parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_BLK-1:0]  inst_block_sigs,
  output logic                block,
  output logic [NUM_AXIS-1:0] block_vec,
  output logic                stall_active
);

  localparam int PW = NUM_BLK + NUM_AXIS;

  stall_state_e  state;
  logic [PW-1:0] pat;
  logic [PW-1:0] pat_q;
  logic          stalled;
  logic          same_pat;
  logic          cnt_inc;
  logic          cnt_restart;
  logic          cnt_hit;

  // A fully idle kernel is never a deadlock candidate.
  assign stalled  = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
  assign pat      = {inst_block_sigs, axis_block_sigs};
  assign same_pat = (pat == pat_q);

  // Counter control: any restart (idle, no stall, or pattern progress) reseeds.
  always_comb begin
    cnt_inc     = 1'b0;
    cnt_restart = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_restart = 1'b1;
        cnt_inc     = stalled;
      end
      S_WATCH: begin
        if (!stalled) begin
          cnt_restart = 1'b1;
        end else if (!same_pat) begin
          cnt_restart = 1'b1;
          cnt_inc     = 1'b1;
        end else begin
          cnt_inc     = 1'b1;
        end
      end
      default: begin
        cnt_inc     = 1'b0;
        cnt_restart = 1'b0;
      end
    endcase
  end

  deadlock_stall_counter #(
    .STALL_CYCLES(STALL_CYCLES)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .inc    (cnt_inc),
    .restart(cnt_restart),
    .hit    (cnt_hit)
  );

  // Decision FSM; S_BLOCKED is absorbing and freezes block/block_vec.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      block     <= 1'b0;
      block_vec <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stalled) begin
            pat_q <= pat;
            state <= S_WATCH;
          end
        end
        S_WATCH: begin
          if (!stalled) begin
            state <= S_IDLE;
          end else if (!same_pat) begin
            pat_q <= pat;
          end else if (cnt_hit) begin
            block     <= 1'b1;
            block_vec <= axis_block_sigs;
            state     <= S_BLOCKED;
          end
        end
        S_BLOCKED: begin
          state <= S_BLOCKED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_active = (state == S_WATCH);

`ifdef DEADLOCK_STALL_REPORT_EN
  logic [31:0] cycle_cnt;

  // Free-running cycle count used to timestamp the deadlock message.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // One message on the S_WATCH -> S_BLOCKED transition.
  always_ff @(posedge clock) begin
    if (reset && (state == S_WATCH) && stalled && same_pat && cnt_hit) begin
      $display("deadlock_stall_detector: deadlock at cycle %0d block_vec=%b inst_block=%b",
               cycle_cnt, axis_block_sigs, inst_block_sigs);
    end
  end
`endif

endmodule

// File: tb/tb_deadlock_stall_detector.sv
// Directed bench for deadlock_stall_detector with STALL_CYCLES=4.
module tb_deadlock_stall_detector;

  localparam int SC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] axis  = '0;
  logic [2:0] idle  = '0;
  logic [0:0] blk   = '0;
  logic       block;
  logic [2:0] block_vec;
  logic       stall_active;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset block
  always #5 clock = ~clock;

  deadlock_stall_detector #(
    .NUM_AXIS(3), .NUM_INST(3), .NUM_BLK(1), .STALL_CYCLES(SC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .axis_block_sigs(axis),
    .inst_idle_sigs (idle),
    .inst_block_sigs(blk),
    .block          (block),
    .block_vec      (block_vec),
    .stall_active   (stall_active)
  );

  // Behavioural model: length of the current run of identical stalled patterns.
  int         m_run  = 0;
  logic [3:0] m_prev = '0;
  logic       m_blk  = 1'b0;
  logic [2:0] m_vec  = '0;
  bit         m_ok   = 0;

  always @(posedge clock) begin
    bit         st;
    logic [3:0] p;
    if (!reset) begin
      m_run = 0;
      m_blk = 1'b0;
      m_vec = '0;
      m_ok  = 1;
    end else if (!m_blk) begin
      st = ((axis != 3'b000) || (blk != 1'b0)) && (idle != 3'b111);
      p  = {blk, axis};
      if (st) begin
        if (m_run > 0 && p == m_prev) m_run = m_run + 1;
        else m_run = 1;
        m_prev = p;
        if (m_run >= SC) begin
          m_blk = 1'b1;
          m_vec = axis;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // Scoreboard: every cycle, DUT outputs against the model.
  always @(negedge clock) begin
    if (m_ok) begin
      n_cmp = n_cmp + 1;
      if ({block, block_vec, stall_active} !== {m_blk, m_vec, (!m_blk && m_run > 0)}) begin
        n_err = n_err + 1;
        $display("FAIL model t=%0t got block=%b vec=%b sa=%b want block=%b vec=%b sa=%b",
                 $time, block, block_vec, stall_active, m_blk, m_vec, (!m_blk && m_run > 0));
      end
    end
  end

  // Driver tasks: inputs change on the falling edge, outputs read there too.
  task automatic cyc(input logic [2:0] a, input logic [2:0] i, input logic b, input int n);
    axis = a; idle = i; blk = b;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic rst_cycles(input int n);
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  initial begin
    @(negedge clock);
    // Reset, then idle inputs
    cyc(3'b000, 3'b000, 1'b0, 0);
    rst_cycles(2);
    check("rst_block", block, 0);
    check("rst_vec", block_vec, 0);
    check("rst_sa", stall_active, 0);
    cyc(3'b000, 3'b000, 1'b0, 10);
    check("quiet_block", block, 0);
    check("quiet_sa", stall_active, 0);

    // Steady stall on stream 0
    rst_cycles(1);
    cyc(3'b001, 3'b000, 1'b0, 1);
    check("s2_sa_e0", stall_active, 1);
    cyc(3'b001, 3'b000, 1'b0, 2);
    check("s2_block_e2", block, 0);
    cyc(3'b001, 3'b000, 1'b0, 1);
    check("s2_block_e3", block, 1);
    check("s2_vec", block_vec, 3'b001);
    check("s2_sa_blocked", stall_active, 0);
    cyc(3'b000, 3'b000, 1'b0, 3);
    check("s2_sticky", block, 1);
    check("s2_vec_frozen", block_vec, 3'b001);

    // Interrupted run restarts
    rst_cycles(1);
    cyc(3'b001, 3'b000, 1'b0, 3);
    cyc(3'b000, 3'b000, 1'b0, 1);
    check("s3_gap_sa", stall_active, 0);
    cyc(3'b001, 3'b000, 1'b0, 3);
    check("s3_block_early", block, 0);
    cyc(3'b001, 3'b000, 1'b0, 1);
    check("s3_block", block, 1);

    // Pattern change restarts at 1
    rst_cycles(1);
    cyc(3'b001, 3'b000, 1'b0, 2);
    cyc(3'b010, 3'b000, 1'b0, 3);
    check("s4_block_early", block, 0);
    cyc(3'b010, 3'b000, 1'b0, 1);
    check("s4_block", block, 1);
    check("s4_vec", block_vec, 3'b010);

    // Pattern change exactly on the terminal edge
    rst_cycles(1);
    cyc(3'b001, 3'b000, 1'b0, 3);
    cyc(3'b100, 3'b000, 1'b0, 1);
    check("term_pat_block", block, 0);
    check("term_pat_sa", stall_active, 1);
    cyc(3'b100, 3'b000, 1'b0, 3);
    check("term_pat_block_late", block, 1);
    check("term_pat_vec", block_vec, 3'b100);

    // Idle-all on the terminal edge
    rst_cycles(1);
    cyc(3'b011, 3'b000, 1'b0, 3);
    cyc(3'b011, 3'b111, 1'b0, 1);
    check("term_idle_block", block, 0);
    check("term_idle_sa", stall_active, 0);

    // Fully idle kernel is never a deadlock
    rst_cycles(1);
    cyc(3'b100, 3'b111, 1'b0, 10);
    check("s5_idle_block", block, 0);
    check("s5_idle_sa", stall_active, 0);

    // Instance-level block only
    rst_cycles(1);
    cyc(3'b000, 3'b000, 1'b1, 3);
    check("s5_inst_early", block, 0);
    cyc(3'b000, 3'b000, 1'b1, 1);
    check("s5_inst_block", block, 1);
    check("s5_inst_vec", block_vec, 3'b000);

    // Reset overrides S_BLOCKED with stall still present
    rst_cycles(1);
    check("s6_rst_block", block, 0);
    check("s6_rst_sa", stall_active, 0);
    cyc(3'b000, 3'b000, 1'b1, 3);
    check("s6_again_early", block, 0);
    cyc(3'b000, 3'b000, 1'b1, 1);
    check("s6_again", block, 1);

    cyc(3'b000, 3'b000, 1'b0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/deadlock_stall_detector.md
# deadlock_stall_detector

Per-kernel deadlock decision stage that consumes the AXI-Stream block vector, instance idle vector and instance block vector gathered by the kernel deadlock monitor top. It reports a deadlock only after the stall pattern has held unchanged for a programmable number of cycles. It drives the single `block` flag back to the top, together with a frozen snapshot of which streams were blocked.

## Interface
- `NUM_AXIS`, 3, number of AXI-Stream blocking channels watched
- `NUM_INST`, 3, number of instance idle flags
- `NUM_BLK`, 1, number of instance-level block flags
- `STALL_CYCLES`, 16, consecutive stalled cycles required to declare deadlock; legal range ≥2
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `axis_block_sigs`  in  NUM_AXIS  bit i high = stream i blocked (blk_n inverted)
- `inst_idle_sigs`  in  NUM_INST  bit j high = instance j idle
- `inst_block_sigs`  in  NUM_BLK  bit k high = instance k internally blocked
- `block`  out  1  deadlock declared; sticky until reset
- `block_vec`  out  NUM_AXIS  axis_block_sigs captured on the cycle block is set
- `stall_active`  out  1  high while a candidate stall is being counted

## Operation
- The combinational term `stalled` = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs).
  - A fully idle kernel is never treated as deadlocked.
- The comparison pattern `pat` = {inst_block_sigs, axis_block_sigs}. The previous pattern is held in `pat_q`.
- FSM states: S_IDLE, S_WATCH, S_BLOCKED. Counter `cnt` is $clog2(STALL_CYCLES+1) bits, unsigned, and never wraps.
- S_IDLE:
  - If `stalled`: cnt←1, pat_q←pat, go to S_WATCH.
  - Otherwise stay, cnt←0.
- S_WATCH:
  - `~stalled`: cnt←0, go to S_IDLE.
  - `stalled` and pat≠pat_q: progress occurred, so cnt←1, pat_q←pat, stay in S_WATCH.
  - `stalled`, pat==pat_q, cnt==STALL_CYCLES-1: block←1, block_vec←axis_block_sigs, go to S_BLOCKED.
  - Otherwise cnt←cnt+1.
- S_BLOCKED:
  - Absorbing. Inputs are ignored, and block and block_vec are frozen until reset.
- `stall_active` = (state==S_WATCH). It is registered-state derived, with no input path.

## Timing
- Reset values (reset sampled low at an edge): state=S_IDLE, cnt=0, pat_q=0, block=0, block_vec=0, stall_active=0.
- Reset takes priority over every transition, including from S_BLOCKED.
- Latency: if `stalled` with an identical pattern is sampled at edges k … k+STALL_CYCLES-1, then `block` is high immediately after edge k+STALL_CYCLES-1.
- One non-stalled or pattern-changed edge restarts the count. A pattern change restarts at 1, not 0.
- Simultaneous events:
  - Pattern change on the terminal edge means no block; cnt←1.
  - Idle-all on the terminal edge means no block; go to S_IDLE.
- Reset deasserted with stall present: the first counted edge is the first edge with reset high.

## Configuration
- `DEADLOCK_STALL_REPORT_EN` defined: a 32-bit free-running cycle counter (reset to 0) is compiled in.
  - On the S_WATCH→S_BLOCKED transition, simulation prints one `$display` line once.
  - The line gives the cycle number, block_vec in binary and inst_block_sigs.
- Macro undefined: no counter and no display. Port list and cycle behaviour are identical.

## Structure
- Shared package `deadlock_mon_pkg`:
  - state enum `stall_state_e` (S_IDLE, S_WATCH, S_BLOCKED)
  - `DEFAULT_STALL_CYCLES` = 16
- One sub-module `deadlock_stall_counter`: a saturating run-length counter with inputs `inc` and `restart` and output `hit` at STALL_CYCLES-1. The FSM stays in the parent.

## Test plan
All scenarios use STALL_CYCLES=4, NUM_AXIS=3, NUM_INST=3, NUM_BLK=1.
- Reset low 2 cycles, all inputs 0, then reset high for 10 cycles → block=0, block_vec=0, stall_active=0 throughout.
- axis=3'b001, idle=3'b000 held from edge 0 → stall_active high after edge 0; block=1 after edge 3; block_vec=3'b001; remains 1 after inputs clear.
- axis=3'b001 for 3 edges, then 3'b000 for 1 edge, then 3'b001 for 4 edges → no block during the first run; block=1 after the 4th edge of the second run.
- axis 001,001,010,010,010,010 → block=1 only after the 4th 010 edge (edge 5); block_vec=3'b010.
- axis=3'b100, idle=3'b111 for 10 edges → block=0 and stall_active=0. Same stimulus with inst_block=1, axis=0, idle=3'b000 → block=1 after 4 edges with block_vec=3'b000.
- Deadlock declared, then reset low 1 edge with stall still applied → block=0 after that edge; block=1 again 4 edges after reset releases.
